// File: rtl/dmem_if.sv
// dmem_if -- data-memory bus interface between the datapath and external memory.
// Latches address/data on a controller load or store request and runs a single
// outstanding req/ack transaction. The core is stalled until the access completes.
// Load data is returned on dIn together with a one-cycle dInValid pulse.
//
// Optional build macro: MEM_TIMEOUT_EN
//   When defined, a watchdog aborts the access after TIMEOUT consecutive REQ
//   cycles without memAck. The abort pulses busErr, and a load returns all-ones.
//   When undefined, REQ waits for memAck indefinitely and busErr is tied low.
module dmem_if #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ldReq,
  input  logic          stReq,
  input  logic [AW-1:0] dAddr,
  input  logic [DW-1:0] dOut,
  output logic [DW-1:0] dIn,
  output logic          dInValid,
  output logic          stall,
  output logic          memReq,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memWData,
  input  logic [DW-1:0] memRData,
  input  logic          memAck,
  output logic          busErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  logic   start;

  // Any controller request; it only has an effect while the FSM is idle.
  assign start = ldReq | stReq;

  // Hold the core from the request cycle through the end of REQ. The hold is
  // released in DONE, so the returned load data is written back in that cycle.
  assign stall = ((state_reg == IDLE) && start) || (state_reg == REQ);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt_reg;
  logic             tmo_hit;

  // This ack-less REQ cycle is the TIMEOUT-th one, so the access is abandoned.
  assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));

  // Count ack-less REQ cycles; clear on entry to REQ and saturate at TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == REQ) && !memAck &&
                 (tmo_cnt_reg != CNT_W'(TIMEOUT))) begin
      tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
    end
  end
`else
  // Without the watchdog, an access can only end on memAck, so no error is reported.
  assign busErr = 1'b0;

  // TIMEOUT is used only by the watchdog build. It is referenced here so that
  // the parameter list stays identical in both builds.
  if (TIMEOUT < 1) begin : g_timeout_param_unused
  end
`endif

  // Access sequencer: IDLE -> REQ -> DONE -> IDLE, with all bus-side outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      dIn       <= '0;
      dInValid  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busErr    <= 1'b0;
`endif
    end else begin
      // The status outputs are single-cycle pulses unless set below.
      dInValid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busErr   <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          // A store takes priority over a simultaneous load. The load is dropped.
          if (start) begin
            memAddr   <= dAddr;
            memWData  <= dOut;
            memWe     <= stReq;
            memReq    <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          // Address, data and direction stay frozen until the access ends.
          if (memAck) begin
            memReq <= 1'b0;
            if (!memWe) begin
              dIn      <= memRData;
              dInValid <= 1'b1;
            end
            state_reg <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            memReq <= 1'b0;
            busErr <= 1'b1;
            if (!memWe) begin
              dIn      <= {DW{1'b1}};
              dInValid <= 1'b1;
            end
            state_reg <= DONE;
          end
`endif
        end
        DONE: begin
          // One turnaround cycle. A new request can be taken in the following IDLE.
          state_reg <= IDLE;
        end
        default: begin
          memReq    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_if.sv
// tb_dmem_if -- self-checking bench for dmem_if.
// Expected load data is queued when a load is issued and checked when dInValid pulses.
`timescale 1ns/1ps
module tb_dmem_if;

  localparam int DW      = 16;
  localparam int AW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          ldReq, stReq;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dOut;
  logic [DW-1:0] dIn;
  logic          dInValid, stall, memReq, memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWData, memRData;
  logic          memAck, busErr;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;

  dmem_if #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ldReq(ldReq), .stReq(stReq), .dAddr(dAddr), .dOut(dOut),
    .dIn(dIn), .dInValid(dInValid), .stall(stall), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWData(memWData), .memRData(memRData), .memAck(memAck),
    .busErr(busErr)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge. Inputs are driven there and checked 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ldReq = 1'b0; stReq = 1'b0; dAddr = '0; dOut = '0;
    memRData = '0; memAck = 1'b0;
    #2;
    vectors++; if (memReq !== 1'b0)    begin miscompares++; $display("FAIL rst_memreq got %b want 0", memReq); end
    vectors++; if (memWe !== 1'b0)     begin miscompares++; $display("FAIL rst_memwe got %b want 0", memWe); end
    vectors++; if (memAddr !== 16'h0)  begin miscompares++; $display("FAIL rst_memaddr got %h want 0000", memAddr); end
    vectors++; if (memWData !== 16'h0) begin miscompares++; $display("FAIL rst_memwdata got %h want 0000", memWData); end
    vectors++; if (dIn !== 16'h0)      begin miscompares++; $display("FAIL rst_din got %h want 0000", dIn); end
    vectors++; if (dInValid !== 1'b0)  begin miscompares++; $display("FAIL rst_dinvalid got %b want 0", dInValid); end
    vectors++; if (busErr !== 1'b0)    begin miscompares++; $display("FAIL rst_buserr got %b want 0", busErr); end
    vectors++; if (stall !== 1'b0)     begin miscompares++; $display("FAIL rst_stall got %b want 0", stall); end
    step(); step();
    reset = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_load_zero_wait();
    step(); ldReq = 1'b1; dAddr = 16'h0040; exp_q.push_back(16'hBEEF); #1;
    vectors++; if (stall !== 1'b1)  begin miscompares++; $display("FAIL ld_c0_stall got %b want 1", stall); end
    vectors++; if (memReq !== 1'b0) begin miscompares++; $display("FAIL ld_c0_memreq got %b want 0", memReq); end
    step(); ldReq = 1'b0; dAddr = 16'hDEAD; memAck = 1'b1; memRData = 16'hBEEF; #1;
    vectors++; if (memReq !== 1'b1)      begin miscompares++; $display("FAIL ld_c1_memreq got %b want 1", memReq); end
    vectors++; if (memWe !== 1'b0)       begin miscompares++; $display("FAIL ld_c1_memwe got %b want 0", memWe); end
    vectors++; if (memAddr !== 16'h0040) begin miscompares++; $display("FAIL ld_c1_memaddr got %h want 0040", memAddr); end
    vectors++; if (stall !== 1'b1)       begin miscompares++; $display("FAIL ld_c1_stall got %b want 1", stall); end
    step(); memAck = 1'b0; memRData = '0; #1;
    vectors++; if (memReq !== 1'b0) begin miscompares++; $display("FAIL ld_c2_memreq got %b want 0", memReq); end
    vectors++; if (stall !== 1'b0)  begin miscompares++; $display("FAIL ld_c2_stall got %b want 0", stall); end
    vectors++;
    if (dInValid !== 1'b1) begin miscompares++; $display("FAIL ld_c2_dinvalid got %b want 1", dInValid); end
    else if (exp_q.size() == 0) begin miscompares++; $display("FAIL ld_c2_sb got empty want entry"); end
    else begin
      exp_d = exp_q.pop_front(); vectors++;
      if (dIn !== exp_d) begin miscompares++; $display("FAIL ld_c2_din got %h want %h", dIn, exp_d); end
    end
    step(); #1;
    vectors++; if (dInValid !== 1'b0) begin miscompares++; $display("FAIL ld_c3_dinvalid got %b want 0", dInValid); end
    vectors++; if (dIn !== 16'hBEEF)  begin miscompares++; $display("FAIL ld_c3_dinhold got %h want beef", dIn); end
    $display("txn load addr=0040 zero-wait data=beef");
  endtask

  task automatic test_store_waits();
    step(); stReq = 1'b1; dAddr = 16'h0100; dOut = 16'h1234; #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL st_c0_stall got %b want 1", stall); end
    for (int c = 1; c <= 5; c++) begin
      step(); stReq = 1'b0; dAddr = 16'(c); dOut = 16'hFFFF - 16'(c); memAck = (c == 5); #1;
      vectors++; if (memReq !== 1'b1)       begin miscompares++; $display("FAIL st_c%0d_memreq got %b want 1", c, memReq); end
      vectors++; if (memWe !== 1'b1)        begin miscompares++; $display("FAIL st_c%0d_memwe got %b want 1", c, memWe); end
      vectors++; if (memWData !== 16'h1234) begin miscompares++; $display("FAIL st_c%0d_wdata got %h want 1234", c, memWData); end
      vectors++; if (memAddr !== 16'h0100)  begin miscompares++; $display("FAIL st_c%0d_addr got %h want 0100", c, memAddr); end
      vectors++; if (stall !== 1'b1)        begin miscompares++; $display("FAIL st_c%0d_stall got %b want 1", c, stall); end
    end
    step(); memAck = 1'b0; #1;
    vectors++; if (memReq !== 1'b0)   begin miscompares++; $display("FAIL st_done_memreq got %b want 0", memReq); end
    vectors++; if (dInValid !== 1'b0) begin miscompares++; $display("FAIL st_done_dinvalid got %b want 0", dInValid); end
    vectors++; if (dIn !== 16'hBEEF)  begin miscompares++; $display("FAIL st_done_din got %h want beef", dIn); end
    vectors++; if (stall !== 1'b0)    begin miscompares++; $display("FAIL st_done_stall got %b want 0", stall); end
    $display("txn store addr=0100 data=1234 waits=4");
  endtask

  task automatic test_both_req();
    step(); ldReq = 1'b1; stReq = 1'b1; dAddr = 16'h0200; dOut = 16'h5555; #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL both_c0_stall got %b want 1", stall); end
    step(); ldReq = 1'b0; stReq = 1'b0; memAck = 1'b1; memRData = 16'h7777; #1;
    vectors++; if (memWe !== 1'b1)        begin miscompares++; $display("FAIL both_memwe got %b want 1", memWe); end
    vectors++; if (memWData !== 16'h5555) begin miscompares++; $display("FAIL both_wdata got %h want 5555", memWData); end
    vectors++; if (memAddr !== 16'h0200)  begin miscompares++; $display("FAIL both_addr got %h want 0200", memAddr); end
    step(); memAck = 1'b0; memRData = '0; #1;
    vectors++; if (dInValid !== 1'b0) begin miscompares++; $display("FAIL both_dinvalid got %b want 0", dInValid); end
    vectors++; if (dIn !== 16'hBEEF)  begin miscompares++; $display("FAIL both_din got %h want beef", dIn); end
    for (int c = 0; c < 4; c++) begin
      step(); #1;
      vectors++; if (memReq !== 1'b0) begin miscompares++; $display("FAIL both_late_read%0d got memReq %b want 0", c, memReq); end
    end
    $display("txn store+load addr=0200 data=5555 (load dropped)");
  endtask

  task automatic test_back_to_back();
    step(); ldReq = 1'b1; dAddr = 16'h1000; exp_q.push_back(16'h1111); #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL b2b_c0_stall got %b want 1", stall); end
    step(); dAddr = 16'h1001; memAck = 1'b1; memRData = 16'h1111; #1;
    vectors++; if (memReq !== 1'b1)      begin miscompares++; $display("FAIL b2b_c1_memreq got %b want 1", memReq); end
    vectors++; if (memAddr !== 16'h1000) begin miscompares++; $display("FAIL b2b_c1_addr got %h want 1000", memAddr); end
    step(); dAddr = 16'h1002; memAck = 1'b0; #1;
    vectors++; if (stall !== 1'b0)  begin miscompares++; $display("FAIL b2b_c2_stall got %b want 0", stall); end
    vectors++; if (memReq !== 1'b0) begin miscompares++; $display("FAIL b2b_c2_memreq got %b want 0", memReq); end
    vectors++;
    if (dInValid !== 1'b1) begin miscompares++; $display("FAIL b2b_c2_dinvalid got %b want 1", dInValid); end
    else if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_c2_sb got empty want entry"); end
    else begin
      exp_d = exp_q.pop_front(); vectors++;
      if (dIn !== exp_d) begin miscompares++; $display("FAIL b2b_c2_din got %h want %h", dIn, exp_d); end
    end
    step(); dAddr = 16'h1003; exp_q.push_back(16'h2222); #1;
    vectors++; if (stall !== 1'b1)  begin miscompares++; $display("FAIL b2b_c3_stall got %b want 1", stall); end
    vectors++; if (memReq !== 1'b0) begin miscompares++; $display("FAIL b2b_c3_memreq got %b want 0", memReq); end
    step(); ldReq = 1'b0; memAck = 1'b1; memRData = 16'h2222; #1;
    vectors++; if (memReq !== 1'b1)      begin miscompares++; $display("FAIL b2b_c4_memreq got %b want 1", memReq); end
    vectors++; if (memAddr !== 16'h1003) begin miscompares++; $display("FAIL b2b_c4_addr got %h want 1003", memAddr); end
    step(); memAck = 1'b0; #1;
    vectors++;
    if (dInValid !== 1'b1) begin miscompares++; $display("FAIL b2b_c5_dinvalid got %b want 1", dInValid); end
    else if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_c5_sb got empty want entry"); end
    else begin
      exp_d = exp_q.pop_front(); vectors++;
      if (dIn !== exp_d) begin miscompares++; $display("FAIL b2b_c5_din got %h want %h", dIn, exp_d); end
    end
    $display("txn load pair addr=1000,1003 data=1111,2222");
  endtask

  task automatic test_reset_mid_access();
    step(); ldReq = 1'b1; dAddr = 16'h3000; dOut = 16'hABCD; #1;
    step(); ldReq = 1'b0; #1;
    vectors++; if (memReq !== 1'b1) begin miscompares++; $display("FAIL rma_c1_memreq got %b want 1", memReq); end
    step(); reset = 1'b1; #1;
    vectors++; if (memReq !== 1'b0)    begin miscompares++; $display("FAIL rma_memreq got %b want 0", memReq); end
    vectors++; if (memWe !== 1'b0)     begin miscompares++; $display("FAIL rma_memwe got %b want 0", memWe); end
    vectors++; if (memAddr !== 16'h0)  begin miscompares++; $display("FAIL rma_memaddr got %h want 0000", memAddr); end
    vectors++; if (memWData !== 16'h0) begin miscompares++; $display("FAIL rma_wdata got %h want 0000", memWData); end
    vectors++; if (dIn !== 16'h0)      begin miscompares++; $display("FAIL rma_din got %h want 0000", dIn); end
    vectors++; if (dInValid !== 1'b0)  begin miscompares++; $display("FAIL rma_dinvalid got %b want 0", dInValid); end
    vectors++; if (busErr !== 1'b0)    begin miscompares++; $display("FAIL rma_buserr got %b want 0", busErr); end
    vectors++; if (stall !== 1'b0)     begin miscompares++; $display("FAIL rma_stall got %b want 0", stall); end
    step(); reset = 1'b0; memAck = 1'b1; memRData = 16'h9999; #1;
    vectors++; if (memReq !== 1'b0) begin miscompares++; $display("FAIL rma_ack_memreq got %b want 0", memReq); end
    step(); memAck = 1'b0; memRData = '0; #1;
    vectors++; if (dInValid !== 1'b0) begin miscompares++; $display("FAIL rma_late_dinvalid got %b want 0", dInValid); end
    vectors++; if (dIn !== 16'h0)     begin miscompares++; $display("FAIL rma_late_din got %h want 0000", dIn); end
    $display("txn load addr=3000 aborted by reset");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    step(); ldReq = 1'b1; dAddr = 16'h4000; exp_q.push_back(16'hFFFF); #1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      step(); ldReq = 1'b0; #1;
      vectors++; if (memReq !== 1'b1) begin miscompares++; $display("FAIL tmo_c%0d_memreq got %b want 1", c, memReq); end
      vectors++; if (busErr !== 1'b0) begin miscompares++; $display("FAIL tmo_c%0d_buserr got %b want 0", c, busErr); end
    end
    step(); #1;
    vectors++; if (memReq !== 1'b0) begin miscompares++; $display("FAIL tmo_done_memreq got %b want 0", memReq); end
    vectors++; if (busErr !== 1'b1) begin miscompares++; $display("FAIL tmo_done_buserr got %b want 1", busErr); end
    vectors++;
    if (dInValid !== 1'b1) begin miscompares++; $display("FAIL tmo_done_dinvalid got %b want 1", dInValid); end
    else if (exp_q.size() == 0) begin miscompares++; $display("FAIL tmo_done_sb got empty want entry"); end
    else begin
      exp_d = exp_q.pop_front(); vectors++;
      if (dIn !== exp_d) begin miscompares++; $display("FAIL tmo_done_din got %h want %h", dIn, exp_d); end
    end
    step(); #1;
    vectors++; if (busErr !== 1'b0) begin miscompares++; $display("FAIL tmo_after_buserr got %b want 0", busErr); end
    $display("txn load addr=4000 timed out");
  endtask

  task automatic test_ack_on_limit();
    step(); ldReq = 1'b1; dAddr = 16'h4400; exp_q.push_back(16'h0A0A); #1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      step(); ldReq = 1'b0; memAck = (c == TIMEOUT); memRData = 16'h0A0A; #1;
      vectors++; if (memReq !== 1'b1) begin miscompares++; $display("FAIL lim_c%0d_memreq got %b want 1", c, memReq); end
    end
    step(); memAck = 1'b0; memRData = '0; #1;
    vectors++; if (busErr !== 1'b0) begin miscompares++; $display("FAIL lim_buserr got %b want 0", busErr); end
    vectors++;
    if (dInValid !== 1'b1) begin miscompares++; $display("FAIL lim_dinvalid got %b want 1", dInValid); end
    else if (exp_q.size() == 0) begin miscompares++; $display("FAIL lim_sb got empty want entry"); end
    else begin
      exp_d = exp_q.pop_front(); vectors++;
      if (dIn !== exp_d) begin miscompares++; $display("FAIL lim_din got %h want %h", dIn, exp_d); end
    end
    $display("txn load addr=4400 ack on last allowed cycle data=0a0a");
  endtask
`else
  task automatic test_no_timeout();
    step(); ldReq = 1'b1; dAddr = 16'h5000; exp_q.push_back(16'hC3C3); #1;
    for (int c = 1; c <= 40; c++) begin
      step(); ldReq = 1'b0; #1;
      vectors++; if (stall !== 1'b1)  begin miscompares++; $display("FAIL hold_c%0d_stall got %b want 1", c, stall); end
      vectors++; if (memReq !== 1'b1) begin miscompares++; $display("FAIL hold_c%0d_memreq got %b want 1", c, memReq); end
      vectors++; if (busErr !== 1'b0) begin miscompares++; $display("FAIL hold_c%0d_buserr got %b want 0", c, busErr); end
    end
    step(); memAck = 1'b1; memRData = 16'hC3C3; #1;
    step(); memAck = 1'b0; memRData = '0; #1;
    vectors++; if (busErr !== 1'b0) begin miscompares++; $display("FAIL hold_done_buserr got %b want 0", busErr); end
    vectors++;
    if (dInValid !== 1'b1) begin miscompares++; $display("FAIL hold_done_dinvalid got %b want 1", dInValid); end
    else if (exp_q.size() == 0) begin miscompares++; $display("FAIL hold_done_sb got empty want entry"); end
    else begin
      exp_d = exp_q.pop_front(); vectors++;
      if (dIn !== exp_d) begin miscompares++; $display("FAIL hold_done_din got %h want %h", dIn, exp_d); end
    end
    $display("txn load addr=5000 held 41 cycles data=c3c3");
  endtask
`endif

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_waits();
    test_both_req();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
    test_ack_on_limit();
`else
    test_no_timeout();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
